// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for an RV32I core.
// Latency: ALU/LUI/AUIPC/JAL/JALR and store 4 cycles, branch 3, load 5, plus one per memory wait cycle.
// Backpressure: holds in FETCH until imem_ready and in MEM until dmem_ready; TRAP is sticky until rst.
// Optional feature macro: SEQ_PERF_CNT_EN adds the cycles/retired performance counters.
module cpu_seq_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_rd,
  output logic             dmem_wr,
  output logic             reg_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic [1:0]       wb_src,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t r_state;

  logic w_is_load;
  logic w_is_store;
  logic w_is_branch;
  logic w_is_jal;
  logic w_is_jalr;
  logic w_legal;

  assign w_is_load   = (opcode == OP_LOAD);
  assign w_is_store  = (opcode == OP_STORE);
  assign w_is_branch = (opcode == OP_BRANCH);
  assign w_is_jal    = (opcode == OP_JAL);
  assign w_is_jalr   = (opcode == OP_JALR);

  // Opcode/funct3 legality, consulted only in DECODE
  always_comb begin
    w_legal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: w_legal = 1'b1;
      OP_LOAD:   w_legal = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
      OP_STORE:  w_legal = (funct3 <= 3'd2);
      OP_BRANCH: w_legal = (funct3 != 3'd2) && (funct3 != 3'd3);
      default:   w_legal = 1'b0;
    endcase
  end

  // Sequencer state register; TRAP only leaves through reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  if (imem_ready) r_state <= S_DECODE;
        S_DECODE: r_state <= w_legal ? S_EXEC : S_TRAP;
        S_EXEC: begin
          if (w_is_branch)                  r_state <= S_FETCH;
          else if (w_is_load || w_is_store) r_state <= S_MEM;
          else                              r_state <= S_WB;
        end
        S_MEM:    if (dmem_ready) r_state <= w_is_load ? S_WB : S_FETCH;
        S_WB:     r_state <= S_FETCH;
        S_TRAP:   r_state <= S_TRAP;
        default:  r_state <= S_TRAP;
      endcase
    end
  end

  logic       w_imem_req;
  logic       w_ir_we;
  logic       w_dmem_rd;
  logic       w_dmem_wr;
  logic       w_reg_we;
  logic       w_pc_we;
  logic [1:0] w_pc_src;
  logic [1:0] w_wb_src;
  logic       w_illegal;

  // Control decode from state plus opcode; ready/branch_taken only feed ir_we, store retire and pc_src
  always_comb begin
    w_imem_req = 1'b0;
    w_ir_we    = 1'b0;
    w_dmem_rd  = 1'b0;
    w_dmem_wr  = 1'b0;
    w_reg_we   = 1'b0;
    w_pc_we    = 1'b0;
    w_pc_src   = 2'd0;
    w_wb_src   = 2'd0;
    w_illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        w_ir_we    = imem_ready;
      end
      S_EXEC: begin
        if (w_is_branch) begin
          w_pc_we  = 1'b1;
          w_pc_src = branch_taken ? 2'd1 : 2'd0;
        end
      end
      S_MEM: begin
        w_dmem_rd = w_is_load;
        w_dmem_wr = w_is_store;
        w_pc_we   = w_is_store && dmem_ready;
      end
      S_WB: begin
        w_reg_we = 1'b1;
        w_pc_we  = 1'b1;
        w_pc_src = w_is_jal ? 2'd1 : (w_is_jalr ? 2'd2 : 2'd0);
        w_wb_src = (w_is_jal || w_is_jalr) ? 2'd2 : (w_is_load ? 2'd1 : 2'd0);
      end
      S_TRAP:  w_illegal = 1'b1;
      default: ;
    endcase
  end

  // Reset forces every output low at once, abandoning any in-flight memory request
  assign imem_req = w_imem_req & ~rst;
  assign ir_we    = w_ir_we    & ~rst;
  assign dmem_rd  = w_dmem_rd  & ~rst;
  assign dmem_wr  = w_dmem_wr  & ~rst;
  assign reg_we   = w_reg_we   & ~rst;
  assign pc_we    = w_pc_we    & ~rst;
  assign illegal  = w_illegal  & ~rst;
  assign pc_src   = rst ? 2'd0 : w_pc_src;
  assign wb_src   = rst ? 2'd0 : w_wb_src;
  assign state    = rst ? 3'd0 : r_state;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycles;
  logic [CNT_W-1:0] r_retired;

  // Free-running cycle and retire counters, frozen once trapped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycles  <= '0;
      r_retired <= '0;
    end else if (r_state != S_TRAP) begin
      r_cycles <= r_cycles + CNT_W'(1);
      if (w_pc_we) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign cycles  = r_cycles;
  assign retired = r_retired;
`else
  assign cycles  = '0;
  assign retired = '0;
`endif

endmodule
